reorder_serial_tagger: RTL and testbench
========================================

Name: reorder_serial_tagger

Overview:
- Sits upstream of the shuffling fabric (crossbar / parallel lanes) that feeds the reorder buffer.
- Stamps every accepted tuple with a monotonically increasing serial tag, modulo 2^SERIAL_WIDTH.
- Grants tags only while the reorder buffer has a free slot, tracking slots with an outstanding-credit counter. A credit is returned by one retire pulse per tuple leaving the reorder output.
- Provides a packet-aligned drain sequence so software can quiesce the reorder path.

Parameters:
- DATA_WIDTH, 64, tuple payload width.
- DEPTH, 512, reorder buffer slots; the maximum number of tuples in flight.
- SERIAL_WIDTH, $clog2(DEPTH), tag width. Elaboration error if DEPTH > 2**SERIAL_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DATA_WIDTH  upstream tuple payload.
- in_keep  in  1  upstream keep flag.
- in_last  in  1  upstream end-of-packet flag.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- out_data  out  DATA_WIDTH  tagged tuple payload.
- out_keep  out  1  tagged tuple keep flag.
- out_last  out  1  tagged tuple end-of-packet flag.
- out_tag  out  SERIAL_WIDTH  serial number assigned to the tuple.
- out_valid  out  1  toward the fabric.
- out_ready  in  1  from the fabric.
- retire_valid  in  1  one-cycle pulse per tuple emitted by the reorder output (out.valid && out.ready there).
- drain_req  in  1  request to quiesce at the next packet boundary.
- drain_done  out  1  one-cycle pulse when the drain completes.
- outstanding  out  SERIAL_WIDTH+1  tuples tagged but not yet retired.
- err_underflow  out  1  sticky flag: a retire arrived with outstanding==0.

Behaviour:
- Reset: out_valid=0, out_tag=0, next_tag=0, outstanding=0, drain_done=0, err_underflow=0, state=RUN. out_data/keep/last are don't-care.
- Reset mid-operation: every tuple in flight is abandoned. The downstream reorder buffer must be reset in the same cycle.
- in_ready = (state==RUN || state==WAIT_LAST) && (outstanding < DEPTH) && (!out_valid || out_ready). Combinational from registers plus out_ready only; no dependence on in_valid.
- Accept (in_valid && in_ready):
  - Next cycle, out_* registers hold the tuple with out_tag=next_tag and out_valid=1.
  - next_tag increments and wraps 2^SERIAL_WIDTH-1 -> 0.
  - outstanding increments.
  - Latency is exactly 1 cycle.
- Output hold: while out_valid && !out_ready, all out_* stay stable. out_valid clears the cycle after a handshake unless a new accept occurs in the same cycle; back-to-back throughput is 1 tuple/cycle.
- Credits:
  - Counted at accept time, not at the output handshake.
  - A retire decrements outstanding.
  - Accept and retire in the same cycle leave outstanding unchanged.
  - A retire with outstanding==0 is ignored and sets err_underflow, which clears only on rst.
- Full: outstanding==DEPTH forces in_ready=0. A retire in that cycle does not re-open in_ready until the next cycle (no combinational path retire->in_ready).
- Tags never reset except by rst; a drain does not reset next_tag, keeping the reorder next pointer aligned.
- FSM:
  - RUN: on drain_req, if packet_open=0 -> DRAIN, else -> WAIT_LAST. packet_open is a register: set on accept with in_last=0, cleared on accept with in_last=1.
  - WAIT_LAST: accepts normally; an accept with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0; when outstanding==0 && !out_valid -> DONE.
  - DONE: drain_done=1 for exactly this cycle, then -> RUN.
  - drain_req is ignored in WAIT_LAST, DRAIN and DONE.
- Simultaneous drain_req and accept in RUN: the accept completes, and packet_open for the transition is evaluated with that accept included.
  - Example: a drain_req in the same cycle as accepting a tuple with in_last=1 goes directly to DRAIN.

Test Plan:
- Reset, then stream 5 tuples with out_ready=1, no retire -> out_tag 0,1,2,3,4 each 1 cycle after accept; outstanding=5; err_underflow=0.
- DEPTH=4, SERIAL_WIDTH=2, 6 tuples offered, no retire -> in_ready drops after 4 accepts. Retire pulse at cycle T -> in_ready=1 at T+1. 5th tuple tagged 0 (wrap).
- out_ready held 0 for 3 cycles with out_valid=1 -> out_data/out_tag stable and in_ready=0. Release -> next tuple follows with no bubble.
- Accept and retire in the same cycle, outstanding=2 -> outstanding stays 2. Retire with outstanding=0 -> err_underflow=1, outstanding stays 0.
- drain_req mid-packet (3-tuple packet, 1 accepted) -> remaining 2 accepted, then in_ready=0. After all 3 retire and out_valid=0 -> drain_done pulses 1 cycle. Next accept gets tag 3, not 0.
- rst asserted with outstanding=3 and out_valid=1 -> next cycle out_valid=0, outstanding=0, state RUN, next accept tagged 0.

Source files
------------

// File: rtl/reorder_serial_tagger.sv
// Serial tagger in front of the shuffling fabric: stamps each accepted tuple with a
// wrapping serial number, limits in-flight tuples to the reorder depth, and drains on packet boundaries.
module reorder_serial_tagger #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 512,
  parameter int SERIAL_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_keep,
  output logic                    out_last,
  output logic [SERIAL_WIDTH-1:0] out_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    retire_valid,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic [SERIAL_WIDTH:0]   outstanding,
  output logic                    err_underflow
);

  if (DEPTH > 2**SERIAL_WIDTH) begin : g_bad_width
    $error("reorder_serial_tagger: SERIAL_WIDTH too small for DEPTH");
  end

  localparam logic [SERIAL_WIDTH:0] DEPTH_C = (SERIAL_WIDTH+1)'(DEPTH);

  // Handshakes: a transfer happens on a port in every cycle where valid && ready;
  // valid never waits on ready, and a raised out_valid holds its payload until taken.
  typedef enum logic [1:0] {ST_RUN, ST_WAIT_LAST, ST_DRAIN, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic [SERIAL_WIDTH-1:0] out_tag_q, out_tag_d;
  logic                    out_valid_q, out_valid_d;
  logic [SERIAL_WIDTH-1:0] next_tag_q, next_tag_d;
  logic [SERIAL_WIDTH:0]   outstanding_q, outstanding_d;
  logic                    packet_open_q, packet_open_d;
  logic                    err_underflow_q, err_underflow_d;

  logic accept;
  logic retire_ok;
  logic accepting_state;

  assign accepting_state = (state_q == ST_RUN) || (state_q == ST_WAIT_LAST);
  // Only registers and out_ready feed in_ready, so a retire re-opens it one cycle later.
  assign in_ready  = accepting_state && (outstanding_q < DEPTH_C) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire_ok = retire_valid && (outstanding_q != '0);

  always_comb begin
    out_data_d      = out_data_q;
    out_keep_d      = out_keep_q;
    out_last_d      = out_last_q;
    out_tag_d       = out_tag_q;
    out_valid_d     = out_valid_q;
    next_tag_d      = next_tag_q;
    packet_open_d   = packet_open_q;
    outstanding_d   = outstanding_q;
    err_underflow_d = err_underflow_q;

    if (accept) begin
      out_data_d    = in_data;
      out_keep_d    = in_keep;
      out_last_d    = in_last;
      out_tag_d     = next_tag_q;
      out_valid_d   = 1'b1;
      next_tag_d    = next_tag_q + SERIAL_WIDTH'(1);
      packet_open_d = !in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({accept, retire_ok})
      2'b10:   outstanding_d = outstanding_q + (SERIAL_WIDTH+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (SERIAL_WIDTH+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (retire_valid && (outstanding_q == '0)) begin
      err_underflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        // packet_open_d already includes an accept happening this cycle.
        if (drain_req) begin
          state_d = packet_open_d ? ST_WAIT_LAST : ST_DRAIN;
        end
      end
      ST_WAIT_LAST: begin
        if (accept && in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && !out_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      out_data_q      <= '0;
      out_keep_q      <= 1'b0;
      out_last_q      <= 1'b0;
      out_tag_q       <= '0;
      out_valid_q     <= 1'b0;
      next_tag_q      <= '0;
      packet_open_q   <= 1'b0;
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_data_q      <= out_data_d;
      out_keep_q      <= out_keep_d;
      out_last_q      <= out_last_d;
      out_tag_q       <= out_tag_d;
      out_valid_q     <= out_valid_d;
      next_tag_q      <= next_tag_d;
      packet_open_q   <= packet_open_d;
      outstanding_q   <= outstanding_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_keep      = out_keep_q;
  assign out_last      = out_last_q;
  assign out_tag       = out_tag_q;
  assign out_valid     = out_valid_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_underflow_q;
  assign drain_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_reorder_serial_tagger.sv
// Directed bench for reorder_serial_tagger with a small reorder depth (8) so
// credit exhaustion and tag wrap are reached quickly.
module tb_reorder_serial_tagger;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_keep;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_keep;
  logic          out_last;
  logic [SW-1:0] out_tag;
  logic          out_valid;
  logic          out_ready;
  logic          retire_valid;
  logic          drain_req;
  logic          drain_done;
  logic [SW:0]   outstanding;
  logic          err_underflow;

  int checks = 0;
  int errors = 0;

  reorder_serial_tagger #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SERIAL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
    .retire_valid(retire_valid), .drain_req(drain_req), .drain_done(drain_done),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_keep = 1'b1; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; retire_valid = 1'b0; drain_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Five tuples streamed back to back: tags 0..4, one cycle after accept.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h100 + i); in_last = (i == 4);
      #1 chk("s_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("s_out_valid", 64'(out_valid), 64'd1);
      chk("s_out_tag", 64'(out_tag), 64'(i));
      chk("s_out_data", 64'(out_data), 64'(16'h100 + i));
      chk("s_out_last", 64'(out_last), 64'(i == 4));
    end
    in_valid = 1'b0;
    tick();
    chk("s_idle_valid", 64'(out_valid), 64'd0);
    chk("s_outstanding", 64'(outstanding), 64'd5);
    chk("s_err", 64'(err_underflow), 64'd0);

    // Three retires, then accept and retire together (outstanding stays at 2).
    retire_valid = 1'b1;
    tick(); tick(); tick();
    chk("r_outstanding3", 64'(outstanding), 64'd2);
    in_valid = 1'b1; in_data = 16'h0aaa; in_last = 1'b1;
    tick();
    chk("ar_outstanding", 64'(outstanding), 64'd2);
    chk("ar_out_tag", 64'(out_tag), 64'd5);
    in_valid = 1'b0;
    tick(); tick();
    chk("r_outstanding0", 64'(outstanding), 64'd0);
    chk("r_err_before", 64'(err_underflow), 64'd0);
    tick();
    retire_valid = 1'b0;
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_outstanding", 64'(outstanding), 64'd0);

    // Fill all 8 credits: tags 6,7,0..5 (wrap), then in_ready must drop.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h200 + i); in_last = 1'b1;
      #1 chk("f_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("f_out_tag", 64'(out_tag), 64'((6 + i) % 8));
    end
    #1 chk("f_full_ready", 64'(in_ready), 64'd0);
    chk("f_outstanding", 64'(outstanding), 64'd8);
    tick();
    chk("f_no_accept", 64'(out_valid), 64'd0);
    retire_valid = 1'b1;
    #1 chk("f_retire_same_cycle", 64'(in_ready), 64'd0);
    tick();
    retire_valid = 1'b0;
    #1 chk("f_reopen", 64'(in_ready), 64'd1);
    chk("f_outstanding7", 64'(outstanding), 64'd7);
    in_data = 16'h0999;
    tick();
    chk("f_ninth_tag", 64'(out_tag), 64'd6);
    chk("f_ninth_data", 64'(out_data), 64'h0999);
    in_valid = 1'b0;
    retire_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    retire_valid = 1'b0;
    chk("f_drained", 64'(outstanding), 64'd0);

    // Backpressure: A held three cycles, then B follows with no bubble.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00a0; in_last = 1'b1;
    tick();
    in_data = 16'h00b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'h00a0);
      chk("bp_tag", 64'(out_tag), 64'd7);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_data", 64'(out_data), 64'h00b0);
    chk("bp_b_tag", 64'(out_tag), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("bp_idle", 64'(out_valid), 64'd0);
    chk("bp_outstanding", 64'(outstanding), 64'd2);
    retire_valid = 1'b1;
    tick(); tick();
    retire_valid = 1'b0;

    // Drain requested mid-packet: finish the packet, then quiesce.
    in_valid = 1'b1; in_data = 16'h0c01; in_last = 1'b0;
    tick();
    chk("d_tag1", 64'(out_tag), 64'd1);
    in_data = 16'h0c02; drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("d_tag2", 64'(out_tag), 64'd2);
    in_data = 16'h0c03; in_last = 1'b1;
    #1 chk("d_wait_last_ready", 64'(in_ready), 64'd1);
    tick();
    chk("d_tag3", 64'(out_tag), 64'd3);
    in_data = 16'h0c04; in_last = 1'b1;
    #1 chk("d_blocked", 64'(in_ready), 64'd0);
    tick();
    chk("d_out_idle", 64'(out_valid), 64'd0);
    chk("d_outstanding", 64'(outstanding), 64'd3);
    retire_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("d_no_done_early", 64'(drain_done), 64'd0);
      tick();
    end
    retire_valid = 1'b0;
    chk("d_no_done_yet", 64'(drain_done), 64'd0);
    tick();
    chk("d_done_pulse", 64'(drain_done), 64'd1);
    chk("d_done_ready", 64'(in_ready), 64'd0);
    tick();
    chk("d_done_clear", 64'(drain_done), 64'd0);
    chk("d_run_ready", 64'(in_ready), 64'd1);
    tick();
    chk("d_next_tag", 64'(out_tag), 64'd4);
    chk("d_next_data", 64'(out_data), 64'h0c04);

    // drain_req together with a closing accept goes straight to DRAIN.
    in_data = 16'h0d05; in_last = 1'b1; drain_req = 1'b1;
    tick();
    drain_req = 1'b0; in_valid = 1'b0;
    chk("dd_tag", 64'(out_tag), 64'd5);
    #1 chk("dd_blocked", 64'(in_ready), 64'd0);
    retire_valid = 1'b1;
    tick(); tick();
    retire_valid = 1'b0;
    chk("dd_outstanding", 64'(outstanding), 64'd0);
    chk("dd_not_yet", 64'(drain_done), 64'd0);
    tick();
    chk("dd_done", 64'(drain_done), 64'd1);
    tick();
    chk("dd_done_clear", 64'(drain_done), 64'd0);

    // Reset mid-operation abandons in-flight tuples and restarts tags.
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(16'h0e00 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("mr_tag", 64'(out_tag), 64'd0);
    chk("mr_outstanding", 64'(outstanding), 64'd3);
    chk("mr_valid", 64'(out_valid), 64'd1);
    chk("mr_err_sticky", 64'(err_underflow), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_rst_valid", 64'(out_valid), 64'd0);
    chk("mr_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mr_rst_err", 64'(err_underflow), 64'd0);
    chk("mr_rst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 16'h0f00; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr_first_tag", 64'(out_tag), 64'd0);
    chk("mr_first_valid", 64'(out_valid), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
